branch_pc_unit: RTL
===================

# branch_pc_unit

- Consumes the `bg`/`les`/`eq` flags produced by the 32-bit zero comparator and resolves MIPS conditional branches and jumps.
- Owns the architectural program counter, computes branch and jump targets, and sequences delay-slot issue.
- Drives the fetch address and a flush pulse to the IF/ID register.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset.
- `CNT_W`, default 16: width of the taken-branch counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `stall`  in  1  hold all state; branch inputs ignored this cycle.
- `br_valid`  in  1  instruction at `pc` is a conditional branch.
- `br_type`  in  3  0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ, 6–7 reserved.
- `bg`, `les`, `eq`  in  1 each  zero-comparator flags. BEQ/BNE: flags of rs−rt. Others: flags of rs.
- `imm`  in  16  branch offset in words, signed.
- `jump`  in  1  instruction at `pc` is J/JAL.
- `jtarget`  in  26  jump index field.
- `pc`  out  32  current fetch address, registered.
- `pc_plus4`  out  32  `pc`+4, combinational.
- `taken`  out  1  registered; 1 for one cycle after a taken branch or jump is accepted.
- `flush`  out  1  registered; squash the IF/ID instruction.
- `slot_err`  out  1  sticky; branch or jump seen in a delay slot.
- `taken_cnt`  out  `CNT_W`  saturating count of accepted taken branches and jumps.

## Operation
Branch condition:
- BEQ: `eq`.
- BNE: `!eq`.
- BLEZ: `les|eq`.
- BGTZ: `bg`.
- BLTZ: `les`.
- BGEZ: `bg|eq`.
- Reserved types: never taken.

Redirect:
- A redirect is `jump`, or `br_valid` with the condition true. `jump` has priority if both are set.
- Branch target: `pc + 4 + (sext(imm) << 2)`, modulo 2^32. Wrap-around is silent.
- Jump target: `{pc_plus4[31:28], jtarget, 2'b00}`.

State machine (state bit, plus a 32-bit `tgt` register):
- SEQ:
  - No redirect: `pc <= pc+4`.
  - Redirect: latch `tgt` and behave per Configuration.
- SLOT (delay-slot build only):
  - `pc <= tgt`, return to SEQ.
  - A `br_valid` or `jump` in this cycle is ignored for control flow and sets `slot_err`.
- `stall`=1 in any state: `pc`, state, `tgt`, `taken_cnt` hold. `taken` and `flush` are 0. Branch inputs are not sampled.
- `taken_cnt` increments once per accepted redirect and saturates at all-ones.
- `slot_err` clears only on reset.

Reset, `rst_n`=0 at an edge:
- `pc`=`RESET_PC`, state SEQ, `tgt`=0.
- `taken`=0, `flush`=0, `slot_err`=0, `taken_cnt`=0.
- Reset mid-SLOT discards the pending target.

## Timing
- Flags and decode inputs are combinational from the current cycle. Decision and target are sampled at the edge ending cycle N.
- Delay-slot build, redirect accepted in cycle N at `pc`=A:
  - `pc`=A+4 in N+1 (SLOT).
  - `pc`=target in N+2, provided N+1 is not stalled.
  - `taken`=1 in N+1. `flush` stays 0.
- No-slot build, redirect accepted in cycle N at `pc`=A:
  - `pc`=target in N+1.
  - `taken`=1 and `flush`=1 in N+1.
- Stall in SLOT extends SLOT by one cycle per stalled cycle. The target is still applied on the first unstalled edge.
- Not-taken branch: identical to a non-branch (`pc+4`); `taken` stays 0.

## Configuration
- Macro `BRANCH_DELAY_SLOT_EN`.
- Defined: SLOT state exists. The instruction at A+4 always executes, `flush` is tied 0, and `slot_err` is active.
- Undefined: no SLOT state. Redirect is immediate with a one-cycle `flush`, and `slot_err` is tied 0.

## Test plan
- Reset with `RESET_PC`=32'h0040_0000, release:
  - Expect `pc` to step 0x00400000 → 0x00400004 → 0x00400008.
  - Expect `taken_cnt`=0.
- BEQ at `pc`=0x00400010, `eq`=1, `imm`=16'hFFFC:
  - Target is 0x00400004.
  - Slot build: `pc` 0x00400014 → 0x00400004.
  - No-slot build: `pc` → 0x00400004 with `flush`=1 for one cycle.
- BGTZ with `bg`=0, `les`=1 at `pc`=0x100:
  - Expect `pc`=0x104, `taken`=0, `taken_cnt` unchanged.
- J at `pc`=0x1000_0020, `jtarget`=26'h000_0040:
  - Expect target 0x1000_0100.
  - Expect `taken_cnt` incremented by 1.
- Slot build: taken branch, then 2 stall cycles in SLOT, with `jump`=1 in the slot:
  - Expect `pc` held at A+4 for 2 cycles, then the original target.
  - Expect `slot_err`=1.
- Wrap and saturation:
  - Branch at `pc`=0xFFFF_FFF8 with `imm`=16'h0002: expect target 0x0000_0004.
  - `CNT_W`=4 with 17 taken jumps: expect `taken_cnt`=4'hF.
  - `rst_n`=0 in SLOT: expect `pc`=`RESET_PC` on the next cycle.

Source files
------------

// File: rtl/branch_pc_unit.sv
// MIPS branch/jump resolution and architectural PC sequencing.
// Build option: `BRANCH_DELAY_SLOT_EN` selects delay-slot issue; without it, redirects are immediate with a flush.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [2:0]       br_type,
  input  logic             bg,
  input  logic             les,
  input  logic             eq,
  input  logic [15:0]      imm,
  input  logic             jump,
  input  logic [25:0]      jtarget,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             taken,
  output logic             flush,
  output logic             slot_err,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic        cond;
  logic        redirect;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] nxt_tgt;

  always_comb begin
    cond = 1'b0;
    case (br_type)
      3'd0:    cond = eq;
      3'd1:    cond = !eq;
      3'd2:    cond = les | eq;
      3'd3:    cond = bg;
      3'd4:    cond = les;
      3'd5:    cond = bg | eq;
      default: cond = 1'b0;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;
  assign br_tgt   = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  assign j_tgt    = {pc_plus4[31:28], jtarget, 2'b00};
  // jump wins over a simultaneously asserted branch
  assign redirect = jump | (br_valid & cond);
  assign nxt_tgt  = jump ? j_tgt : br_tgt;

`ifdef BRANCH_DELAY_SLOT_EN
  typedef enum logic {SEQ, SLOT} st_t;
  st_t         st;
  logic [31:0] tgt;

  assign flush = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      st        <= SEQ;
      tgt       <= 32'h0;
      taken     <= 1'b0;
      slot_err  <= 1'b0;
      taken_cnt <= '0;
    end else begin
      taken <= 1'b0;
      if (!stall) begin
        case (st)
          SEQ: begin
            pc <= pc_plus4;
            if (redirect) begin
              tgt   <= nxt_tgt;
              st    <= SLOT;
              taken <= 1'b1;
              if (taken_cnt != '1) taken_cnt <= taken_cnt + CNT_ONE;
            end
          end
          SLOT: begin
            // control flow in the slot is ignored, only flagged
            pc <= tgt;
            st <= SEQ;
            if (br_valid | jump) slot_err <= 1'b1;
          end
          default: st <= SEQ;
        endcase
      end
    end
  end
`else
  assign slot_err = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      taken     <= 1'b0;
      flush     <= 1'b0;
      taken_cnt <= '0;
    end else begin
      taken <= 1'b0;
      flush <= 1'b0;
      if (!stall) begin
        if (redirect) begin
          pc    <= nxt_tgt;
          taken <= 1'b1;
          flush <= 1'b1;
          if (taken_cnt != '1) taken_cnt <= taken_cnt + CNT_ONE;
        end else begin
          pc <= pc_plus4;
        end
      end
    end
  end
`endif

endmodule
